execute_pipe: RTL and testbench
===============================

EXECUTE_PIPE -- requirements
Module: execute_pipe

Interface
REQ-001 SHALL have parameter N, default 64, datapath width in bits (N >= 8, even).
REQ-002 SHALL have parameter MUL_EN, default 1, enabling the iterative multiply opcode.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid_E  input  1  decode stage presents an operation.
REQ-006 SHALL have port in_ready_E  output  1  stage accepts an operation this cycle.
REQ-007 SHALL have port flush_E  input  1  discards the in-flight operation and the output register.
REQ-008 SHALL have ports AluSrc (input, 1) and AluControl (input, 4); these select operand B and the opcode.
REQ-009 SHALL have ports PC_E, signImm_E, readData1_E and readData2_E, each input, N bits.
REQ-010 SHALL have ports fwdA_E and fwdB_E (input, 2) and fwdMem_E and fwdWb_E (input, N); these are the forwarding selects and forwarded data.
REQ-011 SHALL have ports out_valid_M (output, 1), PCBranch_M, aluResult_M and writeData_M (output, N each) and zero_M (output, 1); all are registered results.

Function
REQ-012 SHALL accept an operation at an edge where in_valid_E && in_ready_E && !flush_E.
REQ-013 SHALL select operand A by fwdA_E: 00 readData1_E, 01 fwdWb_E, 10 fwdMem_E, 11 readData1_E.
REQ-014 SHALL select forwarded B by fwdB_E using the same encoding on readData2_E; operand B = AluSrc ? signImm_E : forwarded B.
REQ-015 SHALL support these opcodes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 pass B, 1100 NOR, 1001 LSL by B[5:0], 1010 LSR by B[5:0], 1000 MUL (low N bits).
REQ-016 SHALL give undefined opcodes, and 1000 when MUL_EN=0, result 0.
REQ-017 SHALL complete non-MUL ops with latency 1: the accept edge loads the output register; out_valid_M is high the following cycle.
REQ-018 SHALL register PCBranch_M = PC_E + (signImm_E << 2), truncated to N bits, with wrap-around.
REQ-019 SHALL register writeData_M as the forwarded B, not operand B.
REQ-020 SHALL register zero_M = (result == 0).
REQ-021 SHALL latch operands, PCBranch and writeData at a MUL accept and enter the BUSY state.
REQ-022 SHALL run MUL as a shift-add, 1 bit per cycle; the result is registered exactly N edges after the accept edge.
REQ-023 SHALL have FSM states IDLE and BUSY: IDLE->BUSY on MUL accept; BUSY->IDLE on count N-1 or on flush_E.
REQ-024 SHALL drive in_ready_E = (state == IDLE).
REQ-025 SHALL hold out_valid_M low during BUSY cycles and high for 1 cycle after MUL completion.
REQ-026 SHALL hold out_valid_M for 1 cycle per accepted op; there is no output backpressure.
REQ-027 SHALL, on flush_E, force out_valid_M to 0 at the next edge, abort BUSY to IDLE and ignore in_valid_E that cycle; flush wins over accept and completion.
REQ-028 SHALL, on an edge with no accept and no completion, clear out_valid_M and hold the data registers.

Reset
REQ-029 SHALL asynchronously, on reset low, set state IDLE, the counter to 0, out_valid_M 0, zero_M 0, and PCBranch_M, aluResult_M and writeData_M to 0.
REQ-030 SHALL, on reset during BUSY, abandon the multiply; no result is produced after release.
REQ-031 SHALL assert in_ready_E in the first cycle after reset release.

Structure
REQ-032 SHALL place the opcode constants, the forwarding-select encodings and the FSM state enum in a shared package execute_pkg.
REQ-033 SHALL implement the multiplier as sub-module mul_iter (start, busy, done; parametrised by N); the single-cycle ops are in execute_pipe.

Verification
REQ-034 SHALL cover: ADD, N=64, A=5, B=7, fwd 00 -> next cycle aluResult_M=12, zero_M=0, out_valid_M=1.
REQ-035 SHALL cover: SUB A=9, fwdB=10 with fwdMem_E=9 -> aluResult_M=0, zero_M=1; writeData_M=9.
REQ-036 SHALL cover: MUL A=6, B=7 at edge k -> in_ready_E low for edges k+1..k+N-1, aluResult_M=42 and out_valid_M=1 after edge k+N only.
REQ-037 SHALL cover: MUL in flight, flush_E at cycle 10 -> in_ready_E=1 next cycle and no out_valid_M pulse.
REQ-038 SHALL cover: PC_E=2^64-4, signImm_E=2 -> PCBranch_M=4, wrapped.
REQ-039 SHALL cover: reset asserted mid-MUL, then released -> all outputs 0, in_ready_E=1, and no late result.

Source files
------------

// File: rtl/execute_pkg.sv
// rtl/execute_pkg.sv - shared opcode, forwarding-select and FSM definitions for the execute stage
package execute_pkg;

    // ALU opcodes presented on AluControl
    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_PASSB = 4'b0111;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_LSL  = 4'b1001;
    localparam logic [3:0] OP_LSR  = 4'b1010;
    localparam logic [3:0] OP_MUL  = 4'b1000;

    // Forwarding selects; 11 aliases the register-file value
    localparam logic [1:0] FWD_REG     = 2'b00;
    localparam logic [1:0] FWD_WB      = 2'b01;
    localparam logic [1:0] FWD_MEM     = 2'b10;
    localparam logic [1:0] FWD_REG_ALT = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/mul_iter.sv
// rtl/mul_iter.sv - iterative shift-add multiplier, one multiplier bit per cycle
//
// Ports:
//   clk, reset      clock and asynchronous active-low reset
//   start           load a/b and begin (ignored while busy)
//   abort           drop the multiply in progress
//   a, b            operands, N bits
//   busy            a multiply is in progress
//   done            high in the last busy cycle; product is valid then
//   product         low N bits of a*b, valid while done is high
module mul_iter #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         abort,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] product
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]  mcand;
    logic [N-1:0]  mplier;
    logic [N-1:0]  acc;
    logic [N-1:0]  acc_next;
    logic [CW-1:0] cnt;

    // The final partial product is folded in combinationally so the caller
    // can register the result on the same edge that ends the iteration.
    assign acc_next = mplier[0] ? (acc + mcand) : acc;
    assign done     = busy && (cnt == CW'(N - 1));
    assign product  = acc_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy   <= 1'b0;
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else if (abort) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (busy) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            if (cnt == CW'(N - 1)) begin
                busy <= 1'b0;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else if (start) begin
            busy   <= 1'b1;
            cnt    <= '0;
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
        end
    end

endmodule

// File: rtl/execute_pipe.sv
// rtl/execute_pipe.sv - execute stage: forwarding, single-cycle ALU, iterative MUL, EX/MEM register
//
// Ports:
//   clk, reset                      clock and asynchronous active-low reset
//   in_valid_E / in_ready_E         operation handshake from decode
//   flush_E                         kill in-flight MUL and the output register
//   AluSrc, AluControl              operand-B select and opcode
//   PC_E, signImm_E                 branch target inputs
//   readData1_E, readData2_E        register-file operands
//   fwdA_E, fwdB_E                  forwarding selects
//   fwdMem_E, fwdWb_E               forwarded data
//   out_valid_M                     one-cycle pulse per completed operation
//   PCBranch_M, aluResult_M,
//   writeData_M, zero_M             registered results
module execute_pipe
    import execute_pkg::*;
#(
    parameter int N      = 64,
    parameter int MUL_EN = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid_E,
    output logic         in_ready_E,
    input  logic         flush_E,
    input  logic         AluSrc,
    input  logic [3:0]   AluControl,
    input  logic [N-1:0] PC_E,
    input  logic [N-1:0] signImm_E,
    input  logic [N-1:0] readData1_E,
    input  logic [N-1:0] readData2_E,
    input  logic [1:0]   fwdA_E,
    input  logic [1:0]   fwdB_E,
    input  logic [N-1:0] fwdMem_E,
    input  logic [N-1:0] fwdWb_E,
    output logic         out_valid_M,
    output logic [N-1:0] PCBranch_M,
    output logic [N-1:0] aluResult_M,
    output logic [N-1:0] writeData_M,
    output logic         zero_M
);

    state_t       state;
    state_t       state_next;
    logic [N-1:0] op_a;
    logic [N-1:0] fwd_b;
    logic [N-1:0] op_b;
    logic [N-1:0] alu_res;
    logic [N-1:0] pc_branch;
    logic [N-1:0] pcb_hold;
    logic [N-1:0] wd_hold;
    logic [N-1:0] mul_product;
    logic         accept;
    logic         is_mul;
    logic         mul_busy;
    logic         mul_done;
    logic         mul_fire;

    assign in_ready_E = (state == ST_IDLE);
    assign accept     = in_valid_E && in_ready_E && !flush_E;
    assign is_mul     = (MUL_EN != 0) && (AluControl == OP_MUL);
    assign mul_fire   = mul_busy && mul_done && (state == ST_BUSY);
    assign pc_branch  = PC_E + (signImm_E << 2);
    assign op_b       = AluSrc ? signImm_E : fwd_b;

    always_comb begin
        op_a = readData1_E;
        case (fwdA_E)
            FWD_WB:  op_a = fwdWb_E;
            FWD_MEM: op_a = fwdMem_E;
            default: op_a = readData1_E;
        endcase
    end

    always_comb begin
        fwd_b = readData2_E;
        case (fwdB_E)
            FWD_WB:  fwd_b = fwdWb_E;
            FWD_MEM: fwd_b = fwdMem_E;
            default: fwd_b = readData2_E;
        endcase
    end

    // MUL is not handled here: it goes through mul_iter, and when the
    // multiplier is disabled the opcode falls into the zero default.
    always_comb begin
        alu_res = '0;
        case (AluControl)
            OP_AND:   alu_res = op_a & op_b;
            OP_OR:    alu_res = op_a | op_b;
            OP_ADD:   alu_res = op_a + op_b;
            OP_SUB:   alu_res = op_a - op_b;
            OP_PASSB: alu_res = op_b;
            OP_NOR:   alu_res = ~(op_a | op_b);
            OP_LSL:   alu_res = op_a << op_b[5:0];
            OP_LSR:   alu_res = op_a >> op_b[5:0];
            default:  alu_res = '0;
        endcase
    end

    mul_iter #(.N(N)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (accept && is_mul),
        .abort   (flush_E),
        .a       (op_a),
        .b       (op_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept && is_mul) state_next = ST_BUSY;
            ST_BUSY: if (flush_E || mul_fire) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Side results of a MUL are captured at accept; decode may move on.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pcb_hold <= '0;
            wd_hold  <= '0;
        end else if (accept && is_mul) begin
            pcb_hold <= pc_branch;
            wd_hold  <= fwd_b;
        end
    end

    // Priority: flush, then MUL completion, then single-cycle accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_M <= 1'b0;
            zero_M      <= 1'b0;
            PCBranch_M  <= '0;
            aluResult_M <= '0;
            writeData_M <= '0;
        end else if (flush_E) begin
            out_valid_M <= 1'b0;
        end else if (mul_fire) begin
            out_valid_M <= 1'b1;
            aluResult_M <= mul_product;
            zero_M      <= (mul_product == '0);
            PCBranch_M  <= pcb_hold;
            writeData_M <= wd_hold;
        end else if (accept && !is_mul) begin
            out_valid_M <= 1'b1;
            aluResult_M <= alu_res;
            zero_M      <= (alu_res == '0);
            PCBranch_M  <= pc_branch;
            writeData_M <= fwd_b;
        end else begin
            out_valid_M <= 1'b0;
        end
    end

endmodule

// File: tb/tb_execute_pipe.sv
// tb/tb_execute_pipe.sv - self-checking bench for execute_pipe against a behavioural model
module tb_execute_pipe;

    localparam int N = 64;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid_E;
    logic         in_ready_E;
    logic         flush_E;
    logic         AluSrc;
    logic [3:0]   AluControl;
    logic [N-1:0] PC_E, signImm_E, readData1_E, readData2_E;
    logic [1:0]   fwdA_E, fwdB_E;
    logic [N-1:0] fwdMem_E, fwdWb_E;
    logic         out_valid_M;
    logic [N-1:0] PCBranch_M, aluResult_M, writeData_M;
    logic         zero_M;

    execute_pipe #(.N(N), .MUL_EN(1)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid_E  (in_valid_E),
        .in_ready_E  (in_ready_E),
        .flush_E     (flush_E),
        .AluSrc      (AluSrc),
        .AluControl  (AluControl),
        .PC_E        (PC_E),
        .signImm_E   (signImm_E),
        .readData1_E (readData1_E),
        .readData2_E (readData2_E),
        .fwdA_E      (fwdA_E),
        .fwdB_E      (fwdB_E),
        .fwdMem_E    (fwdMem_E),
        .fwdWb_E     (fwdWb_E),
        .out_valid_M (out_valid_M),
        .PCBranch_M  (PCBranch_M),
        .aluResult_M (aluResult_M),
        .writeData_M (writeData_M),
        .zero_M      (zero_M)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;
    bit check_en  = 1'b0;

    // Model: what the registered outputs must show after the next rising edge
    logic         exp_valid, exp_ready, exp_zero;
    logic [N-1:0] exp_pcb, exp_alu, exp_wd;
    int           mul_left;
    logic [N-1:0] mul_res, mul_pcb, mul_wd;

    logic [3:0] ops_def [8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110,
                                4'b0111, 4'b1100, 4'b1001, 4'b1010};
    logic [3:0] ops_undef [7] = '{4'b0011, 4'b0100, 4'b0101, 4'b1011,
                                  4'b1101, 4'b1110, 4'b1111};

    task automatic chk(input string name, input logic [N-1:0] got, input logic [N-1:0] want);
        total_cnt++;
        if (got === want) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", name, got, want);
    endtask

    function automatic logic [N-1:0] pick(input logic [1:0] sel, input logic [N-1:0] r);
        if (sel == 2'b01) return fwdWb_E;
        if (sel == 2'b10) return fwdMem_E;
        return r;
    endfunction

    function automatic logic [N-1:0] ref_alu(input logic [3:0] op, input logic [N-1:0] a,
                                             input logic [N-1:0] b);
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0111: return b;
            4'b1100: return ~(a | b);
            4'b1001: return a << b[5:0];
            4'b1010: return a >> b[5:0];
            4'b1000: return a * b;
            default: return '0;
        endcase
    endfunction

    task automatic reset_model();
        exp_valid = 1'b0;
        exp_ready = 1'b1;
        exp_zero  = 1'b0;
        exp_pcb   = '0;
        exp_alu   = '0;
        exp_wd    = '0;
        mul_left  = 0;
    endtask

    task automatic model_update();
        logic [N-1:0] a, fb, b, r, pcb;
        if (!reset) begin
            reset_model();
            return;
        end
        a   = pick(fwdA_E, readData1_E);
        fb  = pick(fwdB_E, readData2_E);
        b   = AluSrc ? signImm_E : fb;
        r   = ref_alu(AluControl, a, b);
        pcb = PC_E + signImm_E * 4;
        if (flush_E) begin
            exp_valid = 1'b0;
            exp_ready = 1'b1;
            mul_left  = 0;
        end else if (mul_left > 0) begin
            mul_left--;
            if (mul_left == 0) begin
                exp_valid = 1'b1;
                exp_ready = 1'b1;
                exp_alu   = mul_res;
                exp_zero  = (mul_res == 0);
                exp_pcb   = mul_pcb;
                exp_wd    = mul_wd;
            end else begin
                exp_valid = 1'b0;
            end
        end else if (in_valid_E) begin
            if (AluControl == 4'b1000) begin
                mul_left  = N;
                mul_res   = r;
                mul_pcb   = pcb;
                mul_wd    = fb;
                exp_ready = 1'b0;
                exp_valid = 1'b0;
            end else begin
                exp_valid = 1'b1;
                exp_alu   = r;
                exp_zero  = (r == 0);
                exp_pcb   = pcb;
                exp_wd    = fb;
            end
        end else begin
            exp_valid = 1'b0;
        end
    endtask

    task automatic tick();
        model_update();
        @(negedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("out_valid_M", N'(out_valid_M), N'(exp_valid));
            chk("in_ready_E",  N'(in_ready_E),  N'(exp_ready));
            chk("zero_M",      N'(zero_M),      N'(exp_zero));
            chk("aluResult_M", aluResult_M,     exp_alu);
            chk("PCBranch_M",  PCBranch_M,      exp_pcb);
            chk("writeData_M", writeData_M,     exp_wd);
        end
    end

    function automatic logic [N-1:0] rnd_word();
        if ($urandom_range(0, 1) == 0) return N'($urandom_range(0, 15));
        return {$urandom, $urandom};
    endfunction

    task automatic set_op(input logic [3:0] op, input logic [N-1:0] rd1, input logic [N-1:0] rd2);
        in_valid_E  = 1'b1;
        flush_E     = 1'b0;
        AluSrc      = 1'b0;
        AluControl  = op;
        readData1_E = rd1;
        readData2_E = rd2;
        fwdA_E      = 2'b00;
        fwdB_E      = 2'b00;
    endtask

    task automatic randomize_inputs();
        int r;
        in_valid_E = ($urandom_range(0, 3) != 0);
        flush_E    = exp_ready ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 149) == 0);
        r = $urandom_range(0, 99);
        if (r < 4)       AluControl = 4'b1000;
        else if (r < 12) AluControl = ops_undef[$urandom_range(0, 6)];
        else             AluControl = ops_def[$urandom_range(0, 7)];
        AluSrc      = $urandom_range(0, 1) != 0;
        fwdA_E      = 2'($urandom_range(0, 3));
        fwdB_E      = 2'($urandom_range(0, 3));
        PC_E        = rnd_word();
        signImm_E   = rnd_word();
        readData1_E = rnd_word();
        readData2_E = ($urandom_range(0, 3) == 0) ? readData1_E : rnd_word();
        fwdMem_E    = rnd_word();
        fwdWb_E     = rnd_word();
    endtask

    initial begin
        int pulses;
        reset       = 1'b0;
        in_valid_E  = 1'b0;
        flush_E     = 1'b0;
        AluSrc      = 1'b0;
        AluControl  = 4'b0000;
        PC_E        = '0;
        signImm_E   = '0;
        readData1_E = '0;
        readData2_E = '0;
        fwdA_E      = 2'b00;
        fwdB_E      = 2'b00;
        fwdMem_E    = '0;
        fwdWb_E     = '0;
        reset_model();
        check_en = 1'b1;

        @(negedge clk);
        #1;
        chk("lit_reset_valid", N'(out_valid_M), '0);
        chk("lit_reset_alu",   aluResult_M,     '0);
        chk("lit_reset_ready", N'(in_ready_E),  N'(1));
        reset = 1'b1;
        chk("lit_ready_after_release", N'(in_ready_E), N'(1));

        // ADD 5 + 7
        set_op(4'b0010, 64'd5, 64'd7);
        tick();
        chk("lit_add_result", aluResult_M,     64'd12);
        chk("lit_add_zero",   N'(zero_M),      '0);
        chk("lit_add_valid",  N'(out_valid_M), N'(1));

        // SUB 9 - forwarded-from-MEM 9
        set_op(4'b0110, 64'd9, 64'd123);
        fwdB_E   = 2'b10;
        fwdMem_E = 64'd9;
        tick();
        chk("lit_sub_result", aluResult_M, '0);
        chk("lit_sub_zero",   N'(zero_M),  N'(1));
        chk("lit_sub_wdata",  writeData_M, 64'd9);

        // Branch target wrap-around
        set_op(4'b0010, 64'd1, 64'd0);
        AluSrc    = 1'b1;
        PC_E      = 64'hFFFF_FFFF_FFFF_FFFC;
        signImm_E = 64'd2;
        tick();
        chk("lit_pcb_wrap", PCBranch_M,  64'd4);
        chk("lit_pcb_alu",  aluResult_M, 64'd3);
        in_valid_E = 1'b0;
        tick();
        chk("lit_idle_valid", N'(out_valid_M), '0);

        // MUL 6 * 7 with exact latency
        set_op(4'b1000, 64'd6, 64'd7);
        tick();
        chk("lit_mul_ready_k", N'(in_ready_E), '0);
        in_valid_E = 1'b0;
        for (int i = 1; i < N; i++) begin
            tick();
            chk("lit_mul_busy_ready", N'(in_ready_E),  '0);
            chk("lit_mul_busy_valid", N'(out_valid_M), '0);
        end
        tick();
        chk("lit_mul_result", aluResult_M,     64'd42);
        chk("lit_mul_valid",  N'(out_valid_M), N'(1));
        chk("lit_mul_ready",  N'(in_ready_E),  N'(1));
        tick();
        chk("lit_mul_pulse_end", N'(out_valid_M), '0);

        // MUL aborted by flush in its tenth busy cycle
        set_op(4'b1000, 64'd3, 64'd11);
        tick();
        in_valid_E = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        flush_E = 1'b1;
        tick();
        chk("lit_flush_ready", N'(in_ready_E),  N'(1));
        chk("lit_flush_valid", N'(out_valid_M), '0);
        flush_E = 1'b0;
        pulses = 0;
        for (int i = 0; i < N + 4; i++) begin
            tick();
            pulses += int'(out_valid_M);
        end
        chk("lit_flush_no_pulse", N'(pulses), '0);

        // Reset in the middle of a MUL
        set_op(4'b1000, 64'd3, 64'd5);
        tick();
        in_valid_E = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        #2;
        reset = 1'b0;
        reset_model();
        #1;
        chk("lit_midrst_alu",   aluResult_M,     '0);
        chk("lit_midrst_wd",    writeData_M,     '0);
        chk("lit_midrst_valid", N'(out_valid_M), '0);
        chk("lit_midrst_ready", N'(in_ready_E),  N'(1));
        tick();
        tick();
        reset = 1'b1;
        pulses = 0;
        for (int i = 0; i < N + 10; i++) begin
            tick();
            pulses += int'(out_valid_M);
        end
        chk("lit_midrst_no_late_result", N'(pulses), '0);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            randomize_inputs();
            tick();
        end
        in_valid_E = 1'b0;
        flush_E    = 1'b0;
        for (int i = 0; i < N + 4; i++) tick();

        check_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
